// File: rtl/fifo_rd_arbiter.sv
// Burst read arbiter draining four source FIFOs into one registered output stream.
// Define FIFO_RD_ARBITER_PRIO0_EN to give channel 0 strict priority at arbitration.
module fifo_rd_arbiter #(
    parameter dta_width = 9'd64,
    parameter burst_len = 9'd8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             fifo_empty,
    input  logic [3:0]             fifo_valid,
    input  logic [4*dta_width-1:0] fifo_dout,
    output logic [3:0]             fifo_rd_en,
    input  logic                   out_almost_full,
    output logic [dta_width-1:0]   dout,
    output logic                   dout_valid,
    output logic [1:0]             dout_chan,
    output logic                   dout_last,
    output logic                   busy
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t               r_state;
    logic [1:0]           r_last_grant;
    logic [1:0]           r_grant;
    logic [8:0]           r_count;
    logic                 r_p1_vld;
    logic [1:0]           r_p1_chan;
    logic                 r_p1_last;
    logic [dta_width-1:0] r_dout;
    logic                 r_dout_valid;
    logic [1:0]           r_dout_chan;
    logic                 r_dout_last;

    logic [2:0]           w_pick;
    logic                 w_rd;
    logic                 w_cnt_last;
    logic                 w_take;
    logic [dta_width-1:0] w_dout_arr [4];

    // Returns {found, index}; the search starts at last+1 so the previous winner goes last.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

`ifdef FIFO_RD_ARBITER_PRIO0_EN
    assign w_pick = fifo_empty[0] ? rr_pick(~fifo_empty & 4'b1110, r_last_grant) : 3'b100;
`else
    assign w_pick = rr_pick(~fifo_empty, r_last_grant);
`endif

    for (genvar g = 0; g < 4; g++) begin : g_split
        assign w_dout_arr[g] = fifo_dout[g*dta_width +: dta_width];
    end

    // Handshake: a read fires when fifo_rd_en[i] is high at a rising edge; the source
    // answers with fifo_valid[i] and its word exactly one cycle later, with no flow control.
    assign w_rd       = (r_state == BURST) & rst & ~fifo_empty[r_grant] & ~out_almost_full
                        & (r_count < burst_len);
    assign w_cnt_last = (r_count == burst_len - 9'd1);
    assign fifo_rd_en = w_rd ? (4'b0001 << r_grant) : 4'b0000;
    assign w_take     = r_p1_vld & fifo_valid[r_p1_chan];
    assign busy       = (r_state == BURST) & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= 2'd3;
            r_grant      <= 2'd0;
            r_count      <= 9'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick[2]) begin
                        r_grant <= w_pick[1:0];
                        r_count <= 9'd0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (w_rd) r_count <= r_count + 9'd1;
                    // Backpressure alone never ends a burst; only count or emptiness does.
                    if ((w_rd && w_cnt_last) || (fifo_empty[r_grant] && !w_rd)) begin
                        r_state      <= IDLE;
                        r_last_grant <= r_grant;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p1_vld     <= 1'b0;
            r_p1_chan    <= 2'd0;
            r_p1_last    <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_dout_chan  <= 2'd0;
            r_dout_last  <= 1'b0;
        end else begin
            r_p1_vld     <= w_rd;
            r_p1_chan    <= r_grant;
            r_p1_last    <= w_rd & w_cnt_last;
            r_dout_valid <= w_take;
            if (w_take) begin
                r_dout      <= w_dout_arr[r_p1_chan];
                r_dout_chan <= r_p1_chan;
                r_dout_last <= r_p1_last;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dout_chan  = r_dout_chan;
    assign dout_last  = r_dout_last;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: four modelled source FIFOs, per-channel data
// queues and an expected-burst queue checked against the output stream.
module tb_fifo_rd_arbiter;

    localparam int W  = 64;
    localparam int BL = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [3:0]     fifo_empty;
    logic [3:0]     fifo_valid = 4'b0000;
    logic [4*W-1:0] fifo_dout;
    logic [3:0]     fifo_rd_en;
    logic           out_almost_full = 1'b0;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic [1:0]     dout_chan;
    logic           dout_last;
    logic           busy;

    fifo_rd_arbiter #(.dta_width(9'd64), .burst_len(9'd8)) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_empty      (fifo_empty),
        .fifo_valid      (fifo_valid),
        .fifo_dout       (fifo_dout),
        .fifo_rd_en      (fifo_rd_en),
        .out_almost_full (out_almost_full),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_chan       (dout_chan),
        .dout_last       (dout_last),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Source FIFO model: word and valid appear one cycle after rd_en.
    logic [W-1:0] mem [4][1024];
    logic [9:0]   wp [4] = '{default: 10'd0};
    logic [9:0]   rp [4] = '{default: 10'd0};
    logic [W-1:0] m_dout [4] = '{default: '0};

    always_comb begin
        fifo_empty = 4'b0000;
        fifo_dout  = '0;
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i]        = (rp[i] == wp[i]);
            fifo_dout[i*W +: W]  = m_dout[i];
        end
    end

    always @(posedge clk) begin
        fifo_valid <= fifo_rd_en;
        for (int i = 0; i < 4; i++) begin
            if (fifo_rd_en[i]) begin
                rp[i]     <= rp[i] + 10'd1;
                m_dout[i] <= mem[i][rp[i]];
            end
        end
    end

    // Scoreboard state
    logic [W-1:0] exp_q [4][$];
    int           exp_bch[$];
    int           exp_blen[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           b_idx   = 0;
    int           cyc     = 0;
    int           prev_cyc = -1;
    int           n_out   = 0;
    int           n_rd    = 0;
    bit           mon_en  = 1'b0;
    bit           chk_gap = 1'b0;
    int           m_ch;
    logic [W-1:0] m_exp;
    string        m_tag;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("rd_safe", fifo_rd_en & fifo_empty, '0);
            check("rd_onehot", ($countones(fifo_rd_en) <= 1), 1);
            if (fifo_rd_en != 4'b0000) n_rd++;
            if (dout_valid) begin
                n_out++;
                if (exp_bch.size() == 0) begin
                    check("spurious", 1, 0);
                end else begin
                    m_ch = exp_bch[0];
                    check("chan", dout_chan, m_ch);
                    if (exp_q[m_ch].size() == 0) begin
                        check("underrun", 1, 0);
                    end else begin
                        m_exp = exp_q[m_ch].pop_front();
                        check("data", dout, m_exp);
                    end
                    b_idx++;
                    check("last", dout_last, (b_idx == BL));
                    if (chk_gap && prev_cyc >= 0) begin
                        m_tag = (b_idx == 1) ? "gap" : "tput";
                        check(m_tag, cyc - prev_cyc, (b_idx == 1) ? 2 : 1);
                    end
                    prev_cyc = cyc;
                    if (b_idx == exp_blen[0]) begin
                        exp_bch.delete(0);
                        exp_blen.delete(0);
                        b_idx = 0;
                    end
                end
            end
        end
        cyc++;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input int n);
        logic [W-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = {$urandom, $urandom};
            mem[ch][wp[ch]] = w;
            wp[ch] = wp[ch] + 10'd1;
            exp_q[ch].push_back(w);
        end
    endtask

    task automatic exp_burst(input int ch, input int len);
        exp_bch.push_back(ch);
        exp_blen.push_back(len);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        b_idx    = 0;
        prev_cyc = -1;
    endtask

    task automatic drain(input string tag);
        int k;
        int left;
        k = 0;
        while (exp_bch.size() != 0 && k < 600) begin
            tick();
            k++;
        end
        check(tag, exp_bch.size(), 0);
        repeat (6) tick();
        left = 0;
        for (int i = 0; i < 4; i++) left += exp_q[i].size();
        check("leftover", left, 0);
    endtask

    task automatic wait_rd(input int target);
        int k;
        k = 0;
        while (n_rd < target && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("wait_rd", (n_rd >= target), 1);
    endtask

    task automatic wait_out(input int target);
        int k;
        k = 0;
        while (n_out < target && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("wait_out", (n_out >= target), 1);
    endtask

    // Drop words the source already gave up but the output never delivered.
    task automatic realign();
        int rem;
        for (int i = 0; i < 4; i++) begin
            rem = int'(wp[i] - rp[i]);
            while (exp_q[i].size() > rem) exp_q[i].delete(0);
        end
        exp_bch.delete();
        exp_blen.delete();
        b_idx    = 0;
        prev_cyc = -1;
    endtask

    initial begin
        int target;
        int rem2;

        rst = 1'b0;
        repeat (3) tick();
        rst    = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_dout", dout, '0);
        check("rst_chan", dout_chan, 0);
        check("rst_last", dout_last, 0);

        // All sources empty: nothing moves.
        repeat (20) begin
            @(negedge clk);
            check("idle_rd", fifo_rd_en, 0);
            check("idle_vld", dout_valid, 0);
            check("idle_busy", busy, 0);
        end

        // Single channel, 20 words: 8 + 8 + 4.
        tick();
        chk_gap = 1'b1;
        exp_burst(2, 8);
        exp_burst(2, 8);
        exp_burst(2, 4);
        load(2, 20);
        drain("drain_ch2");

        // All four channels, 16 words each.
        do_reset();
        chk_gap = 1'b1;
`ifdef FIFO_RD_ARBITER_PRIO0_EN
        exp_burst(0, 8); exp_burst(0, 8);
        exp_burst(1, 8); exp_burst(2, 8); exp_burst(3, 8);
        exp_burst(1, 8); exp_burst(2, 8); exp_burst(3, 8);
`else
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) exp_burst(c, 8);
`endif
        for (int c = 0; c < 4; c++) load(c, 16);
        drain("drain_all4");

        // Backpressure for 5 cycles in the middle of a channel 1 burst.
        do_reset();
        chk_gap = 1'b0;
        exp_burst(1, 8);
        target = n_rd + 3;
        load(1, 8);
        wait_rd(target);
        out_almost_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_rd", fifo_rd_en, 0);
            check("stall_busy", busy, 1);
        end
        tick();
        out_almost_full = 1'b0;
        drain("drain_stall");

        // Reset at the third word of a channel 2 burst, with 0 and 3 waiting.
        do_reset();
        chk_gap = 1'b0;
        exp_burst(2, 8);
        target = n_out + 3;
        load(2, 8);
        wait_out(target);
        rst = 1'b0;
        load(0, 4);
        load(3, 4);
        @(negedge clk);
        check("rst_rd", fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        tick();
        rst = 1'b1;
        realign();
        exp_burst(0, 4);
        rem2 = int'(wp[2] - rp[2]);
        if (rem2 > 0) exp_burst(2, rem2);
        exp_burst(3, 4);
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_rd", fifo_rd_en, 0);
        repeat (3) begin
            check("post_rst_vld", dout_valid, 0);
            @(negedge clk);
        end
        drain("drain_reset");

        // Channels 0 and 3 both loaded.
        do_reset();
        chk_gap = 1'b1;
`ifdef FIFO_RD_ARBITER_PRIO0_EN
        for (int r = 0; r < 4; r++) exp_burst(0, 8);
        for (int r = 0; r < 4; r++) exp_burst(3, 8);
`else
        for (int r = 0; r < 4; r++) begin
            exp_burst(0, 8);
            exp_burst(3, 8);
        end
`endif
        load(0, 32);
        load(3, 32);
        drain("drain_03");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
